// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, a fetch stage that
// issues framebuffer coordinates, and an output stage that drives de, the
// syncs and the frame/line start pulses one cycle after the fetch.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       fetch_en,
   output logic [9:0] fetch_x,
   output logic [9:0] fetch_y,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       frame_start,
   output logic       line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ACT  = 1'(SYNC_POL);
   localparam logic SYNC_IDLE = ~SYNC_ACT;

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       active;
   logic       hs_act;
   logic       vs_act;
   logic       s1_hs;
   logic       s1_vs;

   // Region decodes from the current raster position
   always_comb begin
      active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_act = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
      vs_act = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
   end

   // Raster counters; held at the origin while the pixel PLL is unlocked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!pll_lock) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // Fetch stage: coordinates for the framebuffer plus delayed sync decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_en <= 1'b0;
         fetch_x  <= '0;
         fetch_y  <= '0;
         s1_hs    <= 1'b0;
         s1_vs    <= 1'b0;
      end else if (!pll_lock) begin
         fetch_en <= 1'b0;
         fetch_x  <= '0;
         fetch_y  <= '0;
         s1_hs    <= 1'b0;
         s1_vs    <= 1'b0;
      end else begin
         fetch_en <= active;
         fetch_x  <= active ? h_cnt : '0;
         fetch_y  <= active ? v_cnt : '0;
         s1_hs    <= hs_act;
         s1_vs    <= vs_act;
      end
   end

   // Output stage: aligned with 1-cycle framebuffer read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de          <= 1'b0;
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else if (!pll_lock) begin
         de          <= 1'b0;
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         de          <= fetch_en;
         hsync       <= s1_hs ? SYNC_ACT : SYNC_IDLE;
         vsync       <= s1_vs ? SYNC_ACT : SYNC_IDLE;
         frame_start <= fetch_en && (fetch_x == '0) && (fetch_y == '0);
         line_start  <= fetch_en && (fetch_x == '0);
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a small
// inverted-polarity instance share clock, reset and pll_lock. Expected
// outputs come from a raster-position model and are queued per edge.
module tb_video_timing_gen;

   typedef struct packed {
      logic       fe;
      logic [9:0] fx;
      logic [9:0] fy;
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       ls;
   } obs_t;

   typedef struct {
      obs_t       a;
      obs_t       b;
      logic [19:0] wa;
      logic [19:0] wb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic pll_lock;

   logic       a_fe, a_hs, a_vs, a_de, a_fs, a_ls;
   logic [9:0] a_fx, a_fy;
   logic       b_fe, b_hs, b_vs, b_de, b_fs, b_ls;
   logic [9:0] b_fx, b_fy;

   logic [19:0] ram_a, ram_b;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   n_locked = 0;

   always #5 clk = ~clk;

   video_timing_gen dut_a (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
      .fetch_en(a_fe), .fetch_x(a_fx), .fetch_y(a_fy),
      .hsync(a_hs), .vsync(a_vs), .de(a_de),
      .frame_start(a_fs), .line_start(a_ls)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
      .fetch_en(b_fe), .fetch_x(b_fx), .fetch_y(b_fy),
      .hsync(b_hs), .vsync(b_vs), .de(b_de),
      .frame_start(b_fs), .line_start(b_ls)
   );

   // Framebuffer stand-in: memory word at (x,y) holds {y,x}, 1-cycle read
   always @(posedge clk) begin
      ram_a <= {a_fy, a_fx};
      ram_b <= {b_fy, b_fx};
   end

   // Expected outputs after n consecutive locked edges since reset/unlock
   function automatic void model(input int n, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va,
                                 input int vfp, input int vsw, input int vbp,
                                 input bit pol, output obs_t o,
                                 output logic [19:0] w);
      int ht, vt, k, x, y;
      bit act;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      w = '0;
      if (n >= 1) begin
         k = (n - 1) % (ht * vt);
         x = k % ht;
         y = k / ht;
         if (x < ha && y < va) begin
            o.fe = 1'b1;
            o.fx = 10'(x);
            o.fy = 10'(y);
         end
      end
      if (n >= 2) begin
         k = (n - 2) % (ht * vt);
         x = k % ht;
         y = k / ht;
         act  = (x < ha) && (y < va);
         o.de = act;
         o.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
         o.vs = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
         o.fs = act && x == 0 && y == 0;
         o.ls = act && x == 0;
         w = {10'(y), 10'(x)};
      end
   endfunction

   function automatic obs_t obs_a();
      obs_t o;
      o = {a_fe, a_fx, a_fy, a_de, a_hs, a_vs, a_fs, a_ls};
      return o;
   endfunction

   function automatic obs_t obs_b();
      obs_t o;
      o = {b_fe, b_fx, b_fy, b_de, b_hs, b_vs, b_fs, b_ls};
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual fe=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b required fe=%b x=%0d y=%0d de=%b hs=%b vs=%b fs=%b ls=%b",
                  name, $time, act.fe, act.fx, act.fy, act.de, act.hs, act.vs, act.fs, act.ls,
                  req.fe, req.fx, req.fy, req.de, req.hs, req.vs, req.fs, req.ls);
      end
   endtask

   task automatic check_word(input string name, input logic [19:0] act, input logic [19:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual y=%0d x=%0d required y=%0d x=%0d",
                  name, $time, act[19:10], act[9:0], req[19:10], req[9:0]);
      end
   endtask

   // One clock of stimulus; the expected state after the edge is queued
   task automatic step(input bit lock, input bit rst_release);
      exp_t e;
      obs_t ia, ib;
      logic [19:0] dw;
      @(negedge clk);
      pll_lock = lock;
      if (!rst_release && rst_n === 1'b1) begin
         rst_n = 1'b0;
         #1;
         model(0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ia, dw);
         model(0, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, ib, dw);
         check_obs("async_reset_a", obs_a(), ia);
         check_obs("async_reset_b", obs_b(), ib);
      end else begin
         rst_n = rst_release;
      end
      @(posedge clk);
      if (!rst_n || !pll_lock) n_locked = 0;
      else n_locked++;
      model(n_locked, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, e.a, e.wa);
      model(n_locked, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, e.b, e.wb);
      sb.push_back(e);
   endtask

   // Monitor: compares every edge's outputs and the read data under de
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_obs("outputs_a", obs_a(), e.a);
            check_obs("outputs_b", obs_b(), e.b);
            if (e.a.de) check_word("fetch_align_a", ram_a, e.wa);
            if (e.b.de) check_word("fetch_align_b", ram_b, e.wb);
         end
      end
   end

   initial begin
      int len, r;
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      repeat (3) step(1'b1, 1'b0);
      // Clean lines from reset release
      repeat (2000) step(1'b1, 1'b1);
      // PLL loss mid-line, then relock
      repeat (50) step(1'b0, 1'b1);
      repeat (1700) step(1'b1, 1'b1);
      // Asynchronous reset mid active line
      repeat (2) step(1'b1, 1'b0);
      repeat (1000) step(1'b1, 1'b1);
      // Randomised lock drops and resets
      repeat (50) begin
         len = $urandom_range(20, 600);
         repeat (len) step(1'b1, 1'b1);
         r = $urandom_range(0, 3);
         if (r == 0) begin
            len = $urandom_range(1, 3);
            repeat (len) step(1'($urandom_range(0, 1)), 1'b0);
         end else begin
            len = $urandom_range(1, 60);
            repeat (len) step(1'b0, 1'b1);
         end
      end
      repeat (300) step(1'b1, 1'b1);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
